ball_motion_integrator: RTL and testbench
=========================================

BALL_MOTION_INTEGRATOR -- requirements
Module: ball_motion_integrator

Interface
REQ-001 Parameters SHALL be: SCREEN_WIDTH 640 (pixels); SCREEN_HEIGHT 480 (lines); BALL_SIZE 10 (ball edge, pixels); INIT_X 320 / INIT_Y 240 (serve position); INIT_VX 2 / INIT_VY 2 (serve velocity, signed); ACK_TIMEOUT 15 (cycles to wait for col_ack).
REQ-002 Ports SHALL be, clock and reset first: one clock; reset is asynchronous and active-high: clk in 1 system clock; reset in 1 async active-high reset.
REQ-003 frame_tick in 1: one-cycle pulse per video frame.
REQ-004 serve in 1: restart the ball at the serve position.
REQ-005 col_req out 1: request to the collision stage.
REQ-006 col_ack in 1: collision-stage result valid.
REQ-007 vx_in, vy_in in 16 each: updated velocities, signed two's complement.
REQ-008 ball_x, ball_y out 16 each: current position, unsigned.
REQ-009 ball_vx, ball_vy out 16 each: current velocity, signed.
REQ-010 upd_done out 1: one-cycle pulse when a position update commits.
REQ-011 ack_err out 1: sticky flag set on col_ack timeout.
REQ-012 tick_miss out 8: saturating count of dropped frame ticks.

Function
REQ-013 FSM states SHALL be IDLE, WAIT_TICK, REQ, MOVE, DONE.
REQ-014 IDLE -> WAIT_TICK on serve; WAIT_TICK -> REQ on frame_tick; REQ -> MOVE on col_ack or timeout; MOVE -> DONE unconditionally; DONE -> WAIT_TICK unconditionally.
REQ-015 In REQ, col_req SHALL be high and ball_x/ball_y/ball_vx/ball_vy SHALL be held stable; col_req SHALL be low in every other state.
REQ-016 col_ack high in REQ SHALL capture vx_in/vy_in into ball_vx/ball_vy on that edge; col_ack outside REQ SHALL be ignored.
REQ-017 The timeout counter SHALL clear on entry to REQ; reaching ACK_TIMEOUT cycles without col_ack SHALL keep the old velocities, set ack_err and go to MOVE.
REQ-018 MOVE SHALL compute ball_x += ball_vx and ball_y += ball_vy with 16-bit sign-extended addition, registered on the MOVE->DONE edge.
REQ-019 upd_done SHALL pulse in DONE.
REQ-020 Latency SHALL be frame_tick to upd_done = 3 cycles plus the ack wait, given col_ack in the first REQ cycle.
REQ-021 A frame_tick in any state other than WAIT_TICK SHALL be dropped and increment tick_miss, which saturates at 255.
REQ-022 serve SHALL take priority over all transitions in any state: position and velocity load INIT_*, FSM goes to WAIT_TICK, timeout counter clears; ack_err and tick_miss are retained.
REQ-023 serve and frame_tick in the same cycle: serve wins and the tick is not counted.

Reset
REQ-024 Reset SHALL force state IDLE, ball_x=INIT_X, ball_y=INIT_Y, ball_vx=INIT_VX, ball_vy=INIT_VY, col_req=0, upd_done=0, ack_err=0, tick_miss=0, timeout counter 0.
REQ-025 Reset asserted mid-transaction SHALL abandon any pending col_req immediately, with no upd_done pulse.

Configuration
REQ-026 Macro BALL_CLAMP_EN defined: MOVE results SHALL be clamped to x in [0, SCREEN_WIDTH-BALL_SIZE] and y in [0, SCREEN_HEIGHT-BALL_SIZE], with a negative signed sum treated as 0.
REQ-027 Macro BALL_CLAMP_EN undefined: positions SHALL wrap modulo 2^16 with no clamping.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the screen and ball dimension constants, and the serve defaults; the collision stages use the same package.
REQ-029 One sub-module, ball_pos_clamp, SHALL be natural: combinational add-and-clamp for one axis, instantiated twice, and reduced to a plain add when BALL_CLAMP_EN is undefined.

Verification
REQ-030 Reset release, serve, frame_tick, col_ack with vx_in=3, vy_in=-4 in the first REQ cycle -> ball=(323,236), upd_done 3 cycles after the tick.
REQ-031 frame_tick with col_ack never asserted -> ack_err=1 after 15 REQ cycles, ball=(322,242), velocities unchanged.
REQ-032 300 frame_ticks while in IDLE -> tick_miss=255 and held there.
REQ-033 With BALL_CLAMP_EN defined, ball_y=2, vy_in=-5 -> ball_y=0; with it undefined -> ball_y=65533.
REQ-034 serve asserted during REQ -> col_req drops next cycle, ball=(320,240), no upd_done pulse.
REQ-035 col_ack pulsed during WAIT_TICK -> velocities unchanged, no state change.

Source files
------------

// File: rtl/ball_motion_integrator_pkg.sv
// Shared types and constants for the ball motion integrator and the collision stages.
// Optional position clamping is selected by the BALL_CLAMP_EN macro (see ball_pos_clamp).
package ball_motion_integrator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_REQ       = 3'd2,
        ST_MOVE      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam int SCREEN_WIDTH_DEF  = 640;
    localparam int SCREEN_HEIGHT_DEF = 480;
    localparam int BALL_SIZE_DEF     = 10;
    localparam int INIT_X_DEF        = 320;
    localparam int INIT_Y_DEF        = 240;
    localparam int INIT_VX_DEF       = 2;
    localparam int INIT_VY_DEF       = 2;
    localparam int ACK_TIMEOUT_DEF   = 15;

    localparam int POS_W     = 16;
    localparam int TIMEOUT_W = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ball_pos_clamp.sv
// One-axis position update: pos + signed vel. With BALL_CLAMP_EN defined the result is
// clamped to [0, MAX_POS] (negative sums give 0); otherwise it wraps modulo 2^16.
module ball_pos_clamp
    import ball_motion_integrator_pkg::*;
`ifdef BALL_CLAMP_EN
#(
    parameter int MAX_POS = 630
)
`endif
(
    input  logic [POS_W-1:0] pos,
    input  logic [POS_W-1:0] vel,
    output logic [POS_W-1:0] pos_next
);

`ifdef BALL_CLAMP_EN
    localparam logic signed [17:0] MAX_S = 18'(MAX_POS);

    logic signed [17:0] sum_s;

    // Widened signed sum so that underflow below zero is visible before clamping.
    always_comb begin
        sum_s = $signed({2'b00, pos}) + $signed({{2{vel[15]}}, vel});
        if (sum_s < 18'sd0) begin
            pos_next = 16'd0;
        end else if (sum_s > MAX_S) begin
            pos_next = MAX_S[15:0];
        end else begin
            pos_next = sum_s[15:0];
        end
    end
`else
    assign pos_next = pos + vel;
`endif

endmodule

// File: rtl/ball_motion_integrator.sv
// Per-frame ball integrator: waits for a frame tick, asks the collision stage for new
// velocities (with timeout), then steps the position. BALL_CLAMP_EN enables edge clamping.
module ball_motion_integrator
    import ball_motion_integrator_pkg::*;
#(
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int BALL_SIZE     = BALL_SIZE_DEF,
    parameter int INIT_X        = INIT_X_DEF,
    parameter int INIT_Y        = INIT_Y_DEF,
    parameter int INIT_VX       = INIT_VX_DEF,
    parameter int INIT_VY       = INIT_VY_DEF,
    parameter int ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             serve,
    output logic             col_req,
    input  logic             col_ack,
    input  logic [15:0]      vx_in,
    input  logic [15:0]      vy_in,
    output logic [15:0]      ball_x,
    output logic [15:0]      ball_y,
    output logic [15:0]      ball_vx,
    output logic [15:0]      ball_vy,
    output logic             upd_done,
    output logic             ack_err,
    output logic [7:0]       tick_miss
);

    localparam logic [15:0]          INIT_X_V   = 16'(INIT_X);
    localparam logic [15:0]          INIT_Y_V   = 16'(INIT_Y);
    localparam logic [15:0]          INIT_VX_V  = 16'(INIT_VX);
    localparam logic [15:0]          INIT_VY_V  = 16'(INIT_VY);
    localparam logic [TIMEOUT_W-1:0] TO_LAST    = TIMEOUT_W'(ACK_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [15:0]            x_q, x_d, y_q, y_d;
    logic [15:0]            vx_q, vx_d, vy_q, vy_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   col_req_q, col_req_d;
    logic                   upd_done_q, upd_done_d;
    logic                   ack_err_q, ack_err_d;
    logic [7:0]             tick_miss_q, tick_miss_d;
    logic [15:0]            x_next_s, y_next_s;

`ifdef BALL_CLAMP_EN
    ball_pos_clamp #(.MAX_POS(SCREEN_WIDTH - BALL_SIZE)) u_clamp_x (
        .pos(x_q), .vel(vx_q), .pos_next(x_next_s)
    );
    ball_pos_clamp #(.MAX_POS(SCREEN_HEIGHT - BALL_SIZE)) u_clamp_y (
        .pos(y_q), .vel(vy_q), .pos_next(y_next_s)
    );
`else
    ball_pos_clamp u_clamp_x (.pos(x_q), .vel(vx_q), .pos_next(x_next_s));
    ball_pos_clamp u_clamp_y (.pos(y_q), .vel(vy_q), .pos_next(y_next_s));
`endif

    // Next-state, datapath and registered-output decode; serve overrides every state.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        cnt_d       = cnt_q;
        ack_err_d   = ack_err_q;
        tick_miss_d = tick_miss_q;

        if (frame_tick && !serve && (state_q != ST_WAIT_TICK)) begin
            tick_miss_d = sat_inc8(tick_miss_q);
        end else begin
            tick_miss_d = tick_miss_q;
        end

        if (serve) begin
            state_d = ST_WAIT_TICK;
            x_d     = INIT_X_V;
            y_d     = INIT_Y_V;
            vx_d    = INIT_VX_V;
            vy_d    = INIT_VY_V;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT_TICK: begin
                    if (frame_tick) begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT_TICK;
                    end
                end
                ST_REQ: begin
                    if (col_ack) begin
                        vx_d    = vx_in;
                        vy_d    = vy_in;
                        state_d = ST_MOVE;
                    end else if (cnt_q == TO_LAST) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_MOVE;
                    end else begin
                        cnt_d = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_MOVE: begin
                    x_d     = x_next_s;
                    y_d     = y_next_s;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_WAIT_TICK;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        col_req_d  = (state_d == ST_REQ);
        upd_done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= INIT_X_V;
            y_q         <= INIT_Y_V;
            vx_q        <= INIT_VX_V;
            vy_q        <= INIT_VY_V;
            cnt_q       <= '0;
            col_req_q   <= 1'b0;
            upd_done_q  <= 1'b0;
            ack_err_q   <= 1'b0;
            tick_miss_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            cnt_q       <= cnt_d;
            col_req_q   <= col_req_d;
            upd_done_q  <= upd_done_d;
            ack_err_q   <= ack_err_d;
            tick_miss_q <= tick_miss_d;
        end
    end

    assign col_req   = col_req_q;
    assign upd_done  = upd_done_q;
    assign ack_err   = ack_err_q;
    assign tick_miss = tick_miss_q;
    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign ball_vx   = vx_q;
    assign ball_vy   = vy_q;

endmodule

// File: tb/tb_ball_motion_integrator.sv
// Scoreboard bench for ball_motion_integrator: frames push expected updates, a monitor
// pops and compares on every upd_done pulse.
module tb_ball_motion_integrator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        serve = 1'b0;
    logic        col_req;
    logic        col_ack = 1'b0;
    logic [15:0] vx_in = 16'd0;
    logic [15:0] vy_in = 16'd0;
    logic [15:0] ball_x, ball_y, ball_vx, ball_vy;
    logic        upd_done;
    logic        ack_err;
    logic [7:0]  tick_miss;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int tick_cyc = 0;
    int n_done = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] vx;
        logic [15:0] vy;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

`ifdef BALL_CLAMP_EN
    localparam logic [15:0] Y_UNDER = 16'd0;
`else
    localparam logic [15:0] Y_UNDER = 16'd65533;
`endif

    ball_motion_integrator dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve(serve),
        .col_req(col_req), .col_ack(col_ack), .vx_in(vx_in), .vy_in(vy_in),
        .ball_x(ball_x), .ball_y(ball_y), .ball_vx(ball_vx), .ball_vy(ball_vy),
        .upd_done(upd_done), .ack_err(ack_err), .tick_miss(tick_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: every upd_done pulse must match the oldest expected update.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && upd_done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("unexpected_upd_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("upd_x", {16'd0, ball_x}, {16'd0, e.x});
                    check("upd_y", {16'd0, ball_y}, {16'd0, e.y});
                    check("upd_vx", {16'd0, ball_vx}, {16'd0, e.vx});
                    check("upd_vy", {16'd0, ball_vy}, {16'd0, e.vy});
                    check("upd_ack_err", {31'd0, ack_err}, {31'd0, e.err});
                    check("upd_latency", cyc - tick_cyc, e.lat);
                end
            end
        end
    end

    task automatic do_serve();
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    task automatic frame(input logic do_ack, input logic [15:0] vx, input logic [15:0] vy,
                         input logic [15:0] ex, input logic [15:0] ey,
                         input logic [15:0] evx, input logic [15:0] evy,
                         input logic eerr, input int lat);
        int target;
        sb.push_back('{ex, ey, evx, evy, eerr, lat});
        target = n_done + 1;
        @(negedge clk);
        frame_tick = 1'b1;
        tick_cyc   = cyc;
        @(negedge clk);
        frame_tick = 1'b0;
        check("col_req_in_req", {31'd0, col_req}, 32'd1);
        if (do_ack) begin
            col_ack = 1'b1;
            vx_in   = vx;
            vy_in   = vy;
        end
        @(negedge clk);
        col_ack = 1'b0;
        for (int i = 0; i < 40 && n_done < target; i++) @(negedge clk);
        check("upd_done_seen", (n_done >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_x", {16'd0, ball_x}, 32'd320);
        check("rst_y", {16'd0, ball_y}, 32'd240);
        check("rst_vx", {16'd0, ball_vx}, 32'd2);
        check("rst_vy", {16'd0, ball_vy}, 32'd2);
        check("rst_col_req", {31'd0, col_req}, 32'd0);
        check("rst_upd_done", {31'd0, upd_done}, 32'd0);
        check("rst_ack_err", {31'd0, ack_err}, 32'd0);
        check("rst_tick_miss", {24'd0, tick_miss}, 32'd0);
        reset = 1'b0;

        // serve together with a tick: serve wins, tick not counted
        @(negedge clk);
        serve = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
        check("serve_tick_miss", {24'd0, tick_miss}, 32'd0);
        check("serve_tick_col_req", {31'd0, col_req}, 32'd0);

        frame(1'b1, 16'd3, 16'hFFFC, 16'd323, 16'd236, 16'd3, 16'hFFFC, 1'b0, 3);
        check("tick_miss_after_frame", {24'd0, tick_miss}, 32'd0);

        // col_ack while waiting for a tick is ignored
        @(negedge clk);
        col_ack = 1'b1;
        vx_in = 16'd100;
        vy_in = 16'd100;
        @(negedge clk);
        col_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_ack_vx", {16'd0, ball_vx}, 32'd3);
        check("stray_ack_vy", {16'd0, ball_vy}, 32'h0000FFFC);
        check("stray_ack_col_req", {31'd0, col_req}, 32'd0);
        frame(1'b1, 16'd1, 16'd1, 16'd324, 16'd237, 16'd1, 16'd1, 1'b0, 3);

        // ack timeout keeps the serve velocities
        do_serve();
        check("serve_x", {16'd0, ball_x}, 32'd320);
        check("serve_y", {16'd0, ball_y}, 32'd240);
        frame(1'b0, 16'd0, 16'd0, 16'd322, 16'd242, 16'd2, 16'd2, 1'b1, 17);
        check("timeout_ack_err", {31'd0, ack_err}, 32'd1);

        // underflow at the top edge: clamp or wrap
        do_serve();
        check("ack_err_retained", {31'd0, ack_err}, 32'd1);
        frame(1'b1, 16'd0, 16'hFF12, 16'd320, 16'd2, 16'd0, 16'hFF12, 1'b1, 3);
        frame(1'b1, 16'd0, 16'hFFFB, 16'd320, Y_UNDER, 16'd0, 16'hFFFB, 1'b1, 3);

        // serve during REQ abandons the request
        do_serve();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("abort_col_req_high", {31'd0, col_req}, 32'd1);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        check("abort_col_req_low", {31'd0, col_req}, 32'd0);
        check("abort_x", {16'd0, ball_x}, 32'd320);
        check("abort_y", {16'd0, ball_y}, 32'd240);
        repeat (6) @(negedge clk);
        check("abort_sb_empty", sb.size(), 32'd0);

        // reset mid-request drops col_req at once
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        #2 reset = 1'b1;
        #1 check("async_rst_col_req", {31'd0, col_req}, 32'd0);
        check("async_rst_ack_err", {31'd0, ack_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // dropped ticks in IDLE saturate at 255
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (254) @(negedge clk);
        frame_tick = 1'b0;
        check("tick_miss_254", {24'd0, tick_miss}, 32'd254);
        frame_tick = 1'b1;
        repeat (46) @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("tick_miss_sat", {24'd0, tick_miss}, 32'd255);
        do_serve();
        check("tick_miss_retained", {24'd0, tick_miss}, 32'd255);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
